// File: rtl/if_fetch.sv
// Instruction-fetch controller: PC register, ROM handshake with wait states, IF/ID register.
// Define IF_ROM_WAIT_EN to build the ROM wait-state counter and stallreq_from_if_o.
module if_fetch #(
   parameter int unsigned ROM_WAIT = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [5:0]  stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic        stallreq_from_if_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] buf_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_inst_q;
   logic        rom_ce_q;

   logic        done;
   logic [31:0] word_d;
   logic [31:0] pc_d;
   logic [31:0] if_inst_d;

   // Only the PC stall bit matters here; IF_ID is never released while PC is held.
   logic        unused_stall;
   assign unused_stall = ^stall_i[5:1];

`ifdef IF_ROM_WAIT_EN
   localparam logic [3:0] WAIT_C = 4'(ROM_WAIT);
   logic [3:0] cnt_q;
   assign done = ((state_q == FETCH) && (cnt_q == 4'd0)) || (state_q == HOLD);
   assign stallreq_from_if_o = (state_q == FETCH) && (cnt_q != 4'd0);
`else
   assign done = (state_q == FETCH) || (state_q == HOLD);
   assign stallreq_from_if_o = 1'b0;
`endif

   // HOLD replays the captured word so the ROM is never re-read on release.
   assign word_d    = (state_q == HOLD) ? buf_q : rom_data_i;
   assign pc_d      = branch_flag_i ? branch_target_i : pc_q + 32'd4;
   assign if_inst_d = branch_flag_i ? NOP : word_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         buf_q     <= 32'h0;
         if_pc_q   <= 32'h0;
         if_inst_q <= NOP;
         rom_ce_q  <= 1'b0;
`ifdef IF_ROM_WAIT_EN
         cnt_q     <= 4'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_q  <= FETCH;
               rom_ce_q <= 1'b1;
`ifdef IF_ROM_WAIT_EN
               cnt_q    <= WAIT_C;
`endif
            end
            FETCH, HOLD: begin
               if (done) begin
                  if (stall_i[0]) begin
                     if (state_q == FETCH) buf_q <= rom_data_i;
                     state_q  <= HOLD;
                     rom_ce_q <= 1'b0;
                  end else begin
                     pc_q      <= pc_d;
                     if_pc_q   <= pc_q;
                     if_inst_q <= if_inst_d;
                     state_q   <= FETCH;
                     rom_ce_q  <= 1'b1;
`ifdef IF_ROM_WAIT_EN
                     cnt_q     <= WAIT_C;
`endif
                  end
               end
`ifdef IF_ROM_WAIT_EN
               else begin
                  cnt_q <= cnt_q - 4'd1;
               end
`endif
            end
            default: begin
               state_q  <= IDLE;
               rom_ce_q <= 1'b0;
            end
         endcase
      end
   end

   assign rom_ce_o   = rom_ce_q;
   assign rom_addr_o = pc_q;
   assign pc_o       = if_pc_q;
   assign inst_o     = if_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; the ROM model only returns valid data once an
// address has been held for the effective wait, and returns junk while rom_ce_o is low.
module tb_if_fetch;

`ifdef IF_ROM_WAIT_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = 6'b0;
   logic        br = 1'b0;
   logic [31:0] br_tgt = 32'h0;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        stallreq;
   logic [31:0] pc_o;
   logic [31:0] inst_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   if_fetch #(.ROM_WAIT(2), .RESET_PC(32'h0)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall),
      .branch_flag_i(br), .branch_target_i(br_tgt),
      .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .stallreq_from_if_o(stallreq), .pc_o(pc_o), .inst_o(inst_o)
   );

   // ROM model: word = addr ^ DEAD0000, valid after the address has been held W cycles
   logic [31:0] addr_q = 32'h0;
   logic        ce_q = 1'b0;
   int          age_q = 0;
   logic        same;
   int          cur_age;
   assign same     = rom_ce && ce_q && (rom_addr == addr_q);
   assign cur_age  = same ? age_q + 1 : 0;
   assign rom_data = (rom_ce && cur_age >= W) ? (rom_addr ^ 32'hDEAD_0000) : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      addr_q <= rom_addr;
      ce_q   <= rom_ce;
      age_q  <= cur_age;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      tests++; if (rom_ce !== 1'b0) begin fails++; $display("FAIL reset_rom_ce got %b exp 0", rom_ce); end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL reset_stallreq got %b exp 0", stallreq); end
      tests++; if (rom_addr !== 32'h0) begin fails++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
      tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL reset_pc_o got %h exp 0", pc_o); end
      tests++; if (inst_o !== 32'h0000_0013) begin fails++; $display("FAIL reset_inst got %h exp 00000013", inst_o); end
   endtask

   task automatic test_first_fetch();
      rst = 1'b0;
      tick();
      tests++; if (rom_ce !== 1'b1) begin fails++; $display("FAIL first_rom_ce got %b exp 1", rom_ce); end
      for (int i = 0; i < W; i++) begin
         tests++; if (stallreq !== 1'b1) begin fails++; $display("FAIL first_stallreq_wait%0d got %b exp 1", i, stallreq); end
         tests++; if (rom_addr !== 32'h0) begin fails++; $display("FAIL first_addr_stable%0d got %h exp 0", i, rom_addr); end
         tick();
      end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL first_stallreq_done got %b exp 0", stallreq); end
      tests++; if (inst_o !== 32'h0000_0013) begin fails++; $display("FAIL first_inst_early got %h exp 00000013", inst_o); end
      tick();
      tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL first_pc0 got %h exp 0", pc_o); end
      tests++; if (inst_o !== 32'hDEAD_0000) begin fails++; $display("FAIL first_inst0 got %h exp dead0000", inst_o); end
      tests++; if (rom_addr !== 32'h4) begin fails++; $display("FAIL first_addr4 got %h exp 4", rom_addr); end
      repeat (W) tick();
      tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL first_pc0_held got %h exp 0", pc_o); end
      tick();
      tests++; if (pc_o !== 32'h4) begin fails++; $display("FAIL first_pc4 got %h exp 4", pc_o); end
      tests++; if (inst_o !== 32'hDEAD_0004) begin fails++; $display("FAIL first_inst4 got %h exp dead0004", inst_o); end
   endtask

   // Three more unstalled fetches: 8, C, 10
   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      int          sr_cnt;
      sr_cnt = 0;
      exp_pc = 32'h8;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c <= W; c++) begin
            if (stallreq === 1'b1) sr_cnt++;
            tick();
         end
         tests++; if (pc_o !== exp_pc) begin fails++; $display("FAIL b2b_pc%0d got %h exp %h", k, pc_o, exp_pc); end
         tests++; if (inst_o !== (exp_pc ^ 32'hDEAD_0000)) begin fails++; $display("FAIL b2b_inst%0d got %h exp %h", k, inst_o, exp_pc ^ 32'hDEAD_0000); end
         exp_pc = exp_pc + 32'd4;
      end
      tests++; if (sr_cnt !== 3 * W) begin fails++; $display("FAIL b2b_stallreq_cycles got %0d exp %0d", sr_cnt, 3 * W); end
   endtask

   // Fetch at 0x14 stalls 3 cycles at completion, then releases from the buffer
   task automatic test_hold();
      repeat (W) tick();
      stall = 6'b000111;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (rom_ce !== 1'b0) begin fails++; $display("FAIL hold_rom_ce%0d got %b exp 0", i, rom_ce); end
         tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL hold_stallreq%0d got %b exp 0", i, stallreq); end
         tests++; if (pc_o !== 32'h10) begin fails++; $display("FAIL hold_pc_o%0d got %h exp 10", i, pc_o); end
         tests++; if (inst_o !== 32'hDEAD_0010) begin fails++; $display("FAIL hold_inst%0d got %h exp dead0010", i, inst_o); end
         tests++; if (rom_addr !== 32'h14) begin fails++; $display("FAIL hold_addr%0d got %h exp 14", i, rom_addr); end
      end
      stall = 6'b0;
      tick();
      tests++; if (pc_o !== 32'h14) begin fails++; $display("FAIL hold_rel_pc got %h exp 14", pc_o); end
      tests++; if (inst_o !== 32'hDEAD_0014) begin fails++; $display("FAIL hold_rel_inst got %h exp dead0014", inst_o); end
      tests++; if (rom_addr !== 32'h18) begin fails++; $display("FAIL hold_rel_addr got %h exp 18", rom_addr); end
      tests++; if (rom_ce !== 1'b1) begin fails++; $display("FAIL hold_rel_ce got %b exp 1", rom_ce); end
   endtask

   // Fresh start; branch held for the whole fetch at 0x8 to 0x100
   task automatic test_branch();
      rst = 1'b1; tick();
      rst = 1'b0; tick();
      repeat (2 * (W + 1)) tick();
      tests++; if (rom_addr !== 32'h8) begin fails++; $display("FAIL br_addr8 got %h exp 8", rom_addr); end
      br = 1'b1; br_tgt = 32'h100;
      for (int i = 0; i < W; i++) begin
         tick();
         tests++; if (rom_addr !== 32'h8) begin fails++; $display("FAIL br_wait_addr%0d got %h exp 8", i, rom_addr); end
      end
      tick();
      br = 1'b0;
      tests++; if (pc_o !== 32'h8) begin fails++; $display("FAIL br_pc got %h exp 8", pc_o); end
      tests++; if (inst_o !== 32'h0000_0013) begin fails++; $display("FAIL br_squash got %h exp 00000013", inst_o); end
      tests++; if (rom_addr !== 32'h100) begin fails++; $display("FAIL br_target_addr got %h exp 100", rom_addr); end
      repeat (W + 1) tick();
      tests++; if (pc_o !== 32'h100) begin fails++; $display("FAIL br_tgt_pc got %h exp 100", pc_o); end
      tests++; if (inst_o !== 32'hDEAD_0100) begin fails++; $display("FAIL br_tgt_inst got %h exp dead0100", inst_o); end
      tests++; if (rom_addr !== 32'h104) begin fails++; $display("FAIL br_next_addr got %h exp 104", rom_addr); end
   endtask

   task automatic test_wrap();
      br = 1'b1; br_tgt = 32'hFFFF_FFFC;
      repeat (W + 1) tick();
      br = 1'b0;
      tests++; if (rom_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr_top got %h exp fffffffc", rom_addr); end
      repeat (W + 1) tick();
      tests++; if (pc_o !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h exp fffffffc", pc_o); end
      tests++; if (inst_o !== 32'h2152_FFFC) begin fails++; $display("FAIL wrap_inst got %h exp 2152fffc", inst_o); end
      tests++; if (rom_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr0 got %h exp 0", rom_addr); end
   endtask

   // Reset pulsed with one wait cycle left (any FETCH cycle when waits are off)
   task automatic test_reset_mid();
      if (W > 0) repeat (W - 1) tick();
      tests++; if (rom_ce !== 1'b1) begin fails++; $display("FAIL mid_pre_ce got %b exp 1", rom_ce); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (rom_ce !== 1'b0) begin fails++; $display("FAIL mid_rom_ce got %b exp 0", rom_ce); end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL mid_stallreq got %b exp 0", stallreq); end
      tests++; if (rom_addr !== 32'h0) begin fails++; $display("FAIL mid_addr got %h exp 0", rom_addr); end
      tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL mid_pc_o got %h exp 0", pc_o); end
      tests++; if (inst_o !== 32'h0000_0013) begin fails++; $display("FAIL mid_inst got %h exp 00000013", inst_o); end
      tick();
      tests++; if (rom_ce !== 1'b1) begin fails++; $display("FAIL mid_restart_ce got %b exp 1", rom_ce); end
      repeat (W + 1) tick();
      tests++; if (inst_o !== 32'hDEAD_0000) begin fails++; $display("FAIL mid_refetch got %h exp dead0000", inst_o); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_hold();
      test_branch();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage controller: owns the PC, drives the instruction ROM, and generates the IF-side stall request for the pipeline stall controller. It honours the stall vector that the controller returns and loads the IF/ID pipeline register. ROM wait states raise `stallreq_from_if_o`, which the stall controller maps to `stall = 6'b000111`.

## Interface
- `ROM_WAIT`, default 2: ROM wait cycles per fetch, range 0..15.
- `RESET_PC`, default 32'h0000_0000: first fetch address.
- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous, active-high reset.
- `stall_i` input 6: stall vector from the pipeline stall controller. Bit0 = PC, bit1 = IF_ID; 1 means stop.
- `branch_flag_i` input 1: taken branch/jump resolved in ID.
- `branch_target_i` input 32: redirect address.
- `rom_ce_o` output 1: ROM chip enable.
- `rom_addr_o` output 32: ROM address. Always equals the PC register.
- `rom_data_i` input 32: ROM read data.
- `stallreq_from_if_o` output 1: fetch not yet complete.
- `pc_o` output 32: IF/ID register, PC of the instruction.
- `inst_o` output 32: IF/ID register, instruction.

## Operation
- FSM states: IDLE, FETCH, HOLD. Wait counter `cnt` is 4 bits.
- Reset values: PC = RESET_PC, state IDLE, `cnt` = 0, `rom_ce_o` = 0, `stallreq_from_if_o` = 0, `pc_o` = 0, `inst_o` = 32'h0000_0013 (NOP).
- IDLE → FETCH on the first edge after reset is released; `cnt` loads ROM_WAIT.
- `rom_ce_o` = 1 in FETCH only; it is 0 in IDLE and HOLD.
- FETCH with `cnt` != 0: `stallreq_from_if_o` = 1 (combinational from registers) and `cnt` decrements.
- Completion cycle: FETCH with `cnt` == 0, or HOLD.
  - `stall_i[0]` = 1: go to (or stay in) HOLD. On entry from FETCH, `rom_data_i` is captured into a hold buffer. PC and IF/ID are unchanged.
  - `stall_i[0]` = 0 and `branch_flag_i` = 0: PC ← PC+4, wrapping modulo 2^32. IF/ID ← {PC, fetched word}. The fetched word is `rom_data_i` in FETCH, or the buffer in HOLD.
  - `stall_i[0]` = 0 and `branch_flag_i` = 1: PC ← `branch_target_i`. IF/ID ← {PC, NOP}, so the sequential instruction is squashed.
  - In both `stall_i[0]` = 0 cases, next state is FETCH and `cnt` reloads ROM_WAIT.
- `branch_flag_i` is ignored outside completion cycles. ID keeps the branch asserted while it is stalled.
- IF/ID loads only in completion cycles with `stall_i[0]` = 0; otherwise it holds. The controller never drives `stall_i[1]` = 0 together with `stall_i[0]` = 1.
- Reset mid-fetch: the in-flight fetch is discarded and all state returns to reset values at the next edge.

## Timing
- `rom_addr_o` is stable for the entire fetch.
- `rom_data_i` is sampled at the end of cycle t+ROM_WAIT, where the address was first presented in cycle t.
- Throughput: one instruction per ROM_WAIT+1 cycles when unstalled. With ROM_WAIT = 0, one instruction per cycle and `stallreq_from_if_o` never asserts.
- `stallreq_from_if_o` asserts for exactly ROM_WAIT cycles per fetch, and never in IDLE or HOLD.
- Branch penalty: one squashed slot (NOP) plus ROM_WAIT+1 cycles to fetch the target.
- A HOLD exit (`stall_i[0]` falling) loads IF/ID on that same edge with no ROM re-read.

## Configuration
- `IF_ROM_WAIT_EN` defined: behaviour as above. Wait counter and `stallreq_from_if_o` are implemented.
- `IF_ROM_WAIT_EN` undefined: ROM_WAIT is ignored and treated as 0. `cnt` is removed, `stallreq_from_if_o` is tied to 0, and every FETCH cycle is a completion cycle.

## Test plan
- Reset then release, ROM_WAIT=2, `stall_i`=0: `rom_ce_o` rises one cycle after release. `stallreq_from_if_o` is high for 2 cycles. IF/ID = {0x0, ROM[0]}, then {0x4, ROM[1]} 3 cycles later.
- ROM_WAIT=0, 4 fetches: `pc_o` = 0, 4, 8, C on consecutive cycles; `stallreq_from_if_o` stays 0.
- `stall_i` = 6'b000111 for 3 cycles at a completion: state HOLD, `rom_ce_o` = 0, IF/ID unchanged. IF/ID loads the buffered word on the release edge and PC advances by 4.
- `branch_flag_i` = 1 with target 0x100 at completion of fetch at PC 0x8: IF/ID = {0x8, 0x13}. The next fetch address is 0x100.
- PC = 0xFFFF_FFFC completes: PC wraps to 0x0.
- `rst_i` pulsed during FETCH with `cnt` = 1: the next cycle shows reset values, and IF/ID = {0, NOP}.
